midi_parser_multi: RTL and testbench

- Byte-level MIDI 1.0 stream parser.
- Sits between the UART receiver (31250 baud) and the synth voice/control logic.
- Decodes channel voice messages of 1 or 2 data bytes, supports running status, filters by channel and skips SysEx and system common traffic.
- Forwards system real-time bytes on a separate side port without disturbing message assembly.

---
 rtl/midi_parser_multi_if.sv | 28 ++
 rtl/midi_parser_multi.sv | 230 +++++++++++++++++++++++
 tb/tb_midi_parser_multi.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_parser_multi_if.sv
// Byte and message bundle between a MIDI byte source and midi_parser_multi.
// master: drives received UART bytes, observes decoded messages and side pulses.
// slave : the parser; consumes bytes, drives message fields, real-time and status pulses.
interface midi_parser_multi_if;
  logic [7:0] byte_in;        // received byte from UART
  logic       byte_valid_in;  // one-cycle strobe, byte_in valid
  logic [3:0] status;         // message type nibble (8..E)
  logic [3:0] channel;        // MIDI channel of message
  logic [7:0] data_byte1;     // first data byte
  logic [7:0] data_byte2;     // second data byte, 0 for 1-byte messages
  logic       valid_out;      // one-cycle pulse, message fields valid
  logic [7:0] rt_byte_out;    // system real-time byte (F8-FF)
  logic       rt_valid_out;   // one-cycle pulse for rt_byte_out
  logic       sysex_active;   // high while inside F0..F7
  logic       error_out;      // one-cycle pulse on protocol error

  modport master (
    output byte_in, byte_valid_in,
    input  status, channel, data_byte1, data_byte2, valid_out,
    input  rt_byte_out, rt_valid_out, sysex_active, error_out
  );

  modport slave (
    input  byte_in, byte_valid_in,
    output status, channel, data_byte1, data_byte2, valid_out,
    output rt_byte_out, rt_valid_out, sysex_active, error_out
  );
endinterface

// File: rtl/midi_parser_multi.sv
// MIDI 1.0 byte-stream parser: channel voice messages, running status, SysEx/system common skip.
// Latency: every output pulse is registered, one cycle after the accepting byte strobe.
// Backpressure: none; a byte is consumed on every byte_valid_in cycle (31250 baud is far below clk).
// Ports: clk_in, rst_in (async active-low) plain; bus (slave modport) carries byte input,
//        message fields + valid_out, real-time byte side port, sysex_active and error_out.
module midi_parser_multi #(
  parameter bit         OMNI              = 1'b1,
  parameter logic [3:0] CHANNEL           = 4'd0,
  parameter bit         RUNNING_STATUS_EN = 1'b1,
  parameter bit         NOTE_OFF_CONVERT  = 1'b1
) (
  input logic                clk_in,
  input logic                rst_in,
  midi_parser_multi_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_D1 = 3'd1,
    WAIT_D2 = 3'd2,
    SYSEX   = 3'd3,
    SKIP    = 3'd4
  } state_e;

  state_e     state_q, state_d;
  // Running-status register: last channel status type/channel, and whether it is usable.
  logic       rs_vld_q, rs_vld_d;
  logic [3:0] rs_type_q, rs_type_d;
  logic [3:0] rs_chan_q, rs_chan_d;
  // Needed data-byte count for the current status: 1 = two bytes, 0 = one byte.
  logic       need_two_q, need_two_d;
  logic [1:0] skip_cnt_q, skip_cnt_d;
  logic [7:0] part_d1_q, part_d1_d;

  logic [3:0] status_q, status_d;
  logic [3:0] channel_q, channel_d;
  logic [7:0] data1_q, data1_d;
  logic [7:0] data2_q, data2_d;
  logic       valid_q, valid_d;
  logic [7:0] rt_byte_q, rt_byte_d;
  logic       rt_valid_q, rt_valid_d;
  logic       sysex_q, sysex_d;
  logic       error_q, error_d;

  logic [7:0] in_byte;
  logic       emit;
  logic [7:0] emit_d1;
  logic [7:0] emit_d2;

  always_comb begin
    state_d    = state_q;
    rs_vld_d   = rs_vld_q;
    rs_type_d  = rs_type_q;
    rs_chan_d  = rs_chan_q;
    need_two_d = need_two_q;
    skip_cnt_d = skip_cnt_q;
    part_d1_d  = part_d1_q;
    status_d   = status_q;
    channel_d  = channel_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    valid_d    = 1'b0;
    rt_byte_d  = rt_byte_q;
    rt_valid_d = 1'b0;
    sysex_d    = sysex_q;
    error_d    = 1'b0;
    in_byte    = bus.byte_in;
    emit       = 1'b0;
    emit_d1    = 8'h00;
    emit_d2    = 8'h00;

    if (bus.byte_valid_in) begin
      if (in_byte >= 8'hF8) begin
        // Real-time bytes (including undefined F9/FD) bypass all parse state.
        rt_byte_d  = in_byte;
        rt_valid_d = 1'b1;
      end else if (!in_byte[7]) begin
        case (state_q)
          IDLE: begin
            // A data byte here is data 1 of a new message under running status.
            if (RUNNING_STATUS_EN && rs_vld_q) begin
              if (!need_two_q) begin
                emit    = 1'b1;
                emit_d1 = in_byte;
              end else begin
                part_d1_d = in_byte;
                state_d   = WAIT_D2;
              end
            end else begin
              error_d = 1'b1;
            end
          end
          WAIT_D1: begin
            if (!need_two_q) begin
              emit    = 1'b1;
              emit_d1 = in_byte;
              state_d = IDLE;
            end else begin
              part_d1_d = in_byte;
              state_d   = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d1 = part_d1_q;
            emit_d2 = in_byte;
            state_d = IDLE;
          end
          SKIP: begin
            // System common payload is swallowed; count never starts at 0 in SKIP.
            if (skip_cnt_q == 2'd1) begin
              state_d = IDLE;
            end
            skip_cnt_d = skip_cnt_q - 2'd1;
          end
          SYSEX: begin
            // SysEx payload is discarded.
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end else if (in_byte < 8'hF0) begin
        // Channel status: any partially assembled message or open SysEx is abandoned.
        error_d    = (state_q == WAIT_D1) || (state_q == WAIT_D2) || (state_q == SYSEX);
        rs_vld_d   = 1'b1;
        rs_type_d  = in_byte[7:4];
        rs_chan_d  = in_byte[3:0];
        need_two_d = !((in_byte[7:4] == 4'hC) || (in_byte[7:4] == 4'hD));
        sysex_d    = 1'b0;
        state_d    = WAIT_D1;
      end else begin
        // F0-F7: system exclusive / common; all of them cancel running status.
        rs_vld_d = 1'b0;
        sysex_d  = 1'b0;
        case (in_byte[2:0])
          3'd0: begin
            state_d = SYSEX;
            sysex_d = 1'b1;
          end
          3'd1, 3'd3: begin
            state_d    = SKIP;
            skip_cnt_d = 2'd1;
          end
          3'd2: begin
            state_d    = SKIP;
            skip_cnt_d = 2'd2;
          end
          3'd7: begin
            // F7 only legitimately closes a SysEx; a stray one is an error.
            state_d = IDLE;
            if (state_q != SYSEX) begin
              error_d = 1'b1;
            end
          end
          default: begin
            // F4/F5 undefined, F6 tune request: no payload.
            state_d = IDLE;
          end
        endcase
        // F1-F6 arriving inside SysEx terminate it abnormally.
        if ((state_q == SYSEX) && (in_byte[2:0] != 3'd0) && (in_byte[2:0] != 3'd7)) begin
          error_d = 1'b1;
        end
      end
    end

    // Channel filter: a filtered message still completes its sequencing, silently.
    if (emit && (OMNI || (rs_chan_q == CHANNEL))) begin
      valid_d   = 1'b1;
      channel_d = rs_chan_q;
      data1_d   = emit_d1;
      data2_d   = emit_d2;
      if (NOTE_OFF_CONVERT && (rs_type_q == 4'h9) && (emit_d2 == 8'h00)) begin
        status_d = 4'h8;
      end else begin
        status_d = rs_type_q;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      rs_vld_q   <= 1'b0;
      rs_type_q  <= 4'h0;
      rs_chan_q  <= 4'h0;
      need_two_q <= 1'b0;
      skip_cnt_q <= 2'd0;
      part_d1_q  <= 8'h00;
      status_q   <= 4'h0;
      channel_q  <= 4'h0;
      data1_q    <= 8'h00;
      data2_q    <= 8'h00;
      valid_q    <= 1'b0;
      rt_byte_q  <= 8'h00;
      rt_valid_q <= 1'b0;
      sysex_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_vld_q   <= rs_vld_d;
      rs_type_q  <= rs_type_d;
      rs_chan_q  <= rs_chan_d;
      need_two_q <= need_two_d;
      skip_cnt_q <= skip_cnt_d;
      part_d1_q  <= part_d1_d;
      status_q   <= status_d;
      channel_q  <= channel_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      valid_q    <= valid_d;
      rt_byte_q  <= rt_byte_d;
      rt_valid_q <= rt_valid_d;
      sysex_q    <= sysex_d;
      error_q    <= error_d;
    end
  end

  assign bus.status       = status_q;
  assign bus.channel      = channel_q;
  assign bus.data_byte1   = data1_q;
  assign bus.data_byte2   = data2_q;
  assign bus.valid_out    = valid_q;
  assign bus.rt_byte_out  = rt_byte_q;
  assign bus.rt_valid_out = rt_valid_q;
  assign bus.sysex_active = sysex_q;
  assign bus.error_out    = error_q;

endmodule

// File: tb/tb_midi_parser_multi.sv
// Self-checking bench for midi_parser_multi: three parameterisations fed one at a time,
// expected messages/real-time bytes queued at stimulus time and popped when the DUT pulses.
module tb_midi_parser_multi;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  midi_parser_multi_if b0 ();
  midi_parser_multi_if b1 ();
  midi_parser_multi_if b2 ();

  midi_parser_multi dut0 (.clk_in(clk_in), .rst_in(rst_in), .bus(b0));
  midi_parser_multi #(.RUNNING_STATUS_EN(1'b0)) dut1 (.clk_in(clk_in), .rst_in(rst_in), .bus(b1));
  midi_parser_multi #(.OMNI(1'b0), .CHANNEL(4'd3)) dut2 (.clk_in(clk_in), .rst_in(rst_in), .bus(b2));

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Scoreboard entries carry the DUT index so a pulse on the wrong instance is caught.
  logic [25:0] exp_q [$];   // {idx[1:0], status, channel, d1, d2}
  logic [9:0]  rt_q  [$];   // {idx[1:0], byte}
  int err_cnt [3];
  int e_err   [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_msg(input logic [1:0] k, input logic [3:0] st, input logic [3:0] ch,
                         input logic [7:0] d1, input logic [7:0] d2);
    exp_q.push_back({k, st, ch, d1, d2});
  endtask

  task automatic mon_msg(input logic [1:0] k, input logic [3:0] st, input logic [3:0] ch,
                         input logic [7:0] d1, input logic [7:0] d2);
    logic [25:0] e;
    chk("msg_was_expected", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("msg_fields", 32'({k, st, ch, d1, d2}), 32'(e));
    end
  endtask

  task automatic mon_rt(input logic [1:0] k, input logic [7:0] b);
    logic [9:0] e;
    chk("rt_was_expected", 32'(rt_q.size() > 0), 32'd1);
    if (rt_q.size() > 0) begin
      e = rt_q.pop_front();
      chk("rt_byte", 32'({k, b}), 32'(e));
    end
  endtask

  always @(negedge clk_in) begin
    if (b0.valid_out === 1'b1) mon_msg(2'd0, b0.status, b0.channel, b0.data_byte1, b0.data_byte2);
    if (b1.valid_out === 1'b1) mon_msg(2'd1, b1.status, b1.channel, b1.data_byte1, b1.data_byte2);
    if (b2.valid_out === 1'b1) mon_msg(2'd2, b2.status, b2.channel, b2.data_byte1, b2.data_byte2);
    if (b0.rt_valid_out === 1'b1) mon_rt(2'd0, b0.rt_byte_out);
    if (b1.rt_valid_out === 1'b1) mon_rt(2'd1, b1.rt_byte_out);
    if (b2.rt_valid_out === 1'b1) mon_rt(2'd2, b2.rt_byte_out);
    if (b0.error_out === 1'b1) err_cnt[0]++;
    if (b1.error_out === 1'b1) err_cnt[1]++;
    if (b2.error_out === 1'b1) err_cnt[2]++;
  end

  // One strobe per call; returns on the negedge right after the accepting posedge.
  task automatic send(input int k, input logic [7:0] b);
    @(negedge clk_in);
    case (k)
      0: begin b0.byte_in = b; b0.byte_valid_in = 1'b1; end
      1: begin b1.byte_in = b; b1.byte_valid_in = 1'b1; end
      default: begin b2.byte_in = b; b2.byte_valid_in = 1'b1; end
    endcase
    @(negedge clk_in);
    b0.byte_valid_in = 1'b0;
    b1.byte_valid_in = 1'b0;
    b2.byte_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic chk_err(input string tag, input int k);
    idle(1);
    chk(tag, 32'(err_cnt[k]), 32'(e_err[k]));
  endtask

  initial begin
    b0.byte_in = 8'h00; b0.byte_valid_in = 1'b0;
    b1.byte_in = 8'h00; b1.byte_valid_in = 1'b0;
    b2.byte_in = 8'h00; b2.byte_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      err_cnt[i] = 0;
      e_err[i]   = 0;
    end
    #12;
    chk("reset_outs_dut0", 32'({b0.status, b0.channel, b0.data_byte1, b0.data_byte2}), 32'd0);
    chk("reset_flags_dut0", 32'({b0.valid_out, b0.rt_byte_out, b0.rt_valid_out,
                                 b0.sysex_active, b0.error_out}), 32'd0);
    chk("reset_outs_dut2", 32'({b2.status, b2.channel, b2.data_byte1, b2.data_byte2}), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(2);

    // Basic note on, valid exactly one cycle after the last data strobe.
    exp_msg(0, 4'h9, 4'h0, 8'h3C, 8'h64);
    send(0, 8'h90); send(0, 8'h3C); send(0, 8'h64);
    chk("note_on_valid_now", 32'(b0.valid_out), 32'd1);
    idle(1);
    chk("note_on_valid_gone", 32'(b0.valid_out), 32'd0);
    idle(2);
    chk("fields_hold", 32'({b0.status, b0.data_byte1, b0.data_byte2}), 32'h93C64);
    // Running status with velocity 0: converted to note off.
    exp_msg(0, 4'h8, 4'h0, 8'h3C, 8'h00);
    send(0, 8'h3C); send(0, 8'h00);

    // Running status, two pulses.
    exp_msg(0, 4'h9, 4'h1, 8'h40, 8'h50);
    exp_msg(0, 4'h9, 4'h1, 8'h41, 8'h51);
    send(0, 8'h91); send(0, 8'h40); send(0, 8'h50); send(0, 8'h41); send(0, 8'h51);
    chk_err("rs_no_error", 0);

    // Running status disabled: 41 and 51 both rejected.
    exp_msg(1, 4'h9, 4'h1, 8'h40, 8'h50);
    send(1, 8'h91); send(1, 8'h40); send(1, 8'h50); send(1, 8'h41);
    e_err[1] = 1;
    chk_err("rs_off_err_41", 1);
    send(1, 8'h51);
    e_err[1] = 2;
    chk_err("rs_off_err_51", 1);

    // Program change then running-status repeat.
    exp_msg(0, 4'hC, 4'h5, 8'h07, 8'h00);
    send(0, 8'hC5); send(0, 8'h07);
    exp_msg(0, 4'hC, 4'h5, 8'h08, 8'h00);
    send(0, 8'h08);

    // Real-time interleaved in WAIT_D1 and WAIT_D2.
    rt_q.push_back({2'd0, 8'hF8});
    rt_q.push_back({2'd0, 8'hFA});
    exp_msg(0, 4'h9, 4'h0, 8'h3C, 8'h7F);
    send(0, 8'h90); send(0, 8'hF8); send(0, 8'h3C); send(0, 8'hFA); send(0, 8'h7F);
    chk_err("rt_no_error", 0);

    // SysEx with real-time inside, then a note off.
    send(0, 8'hF0);
    chk("sysex_on", 32'(b0.sysex_active), 32'd1);
    rt_q.push_back({2'd0, 8'hFE});
    send(0, 8'h01); send(0, 8'hFE); send(0, 8'h02);
    chk("sysex_held", 32'(b0.sysex_active), 32'd1);
    send(0, 8'hF7);
    chk("sysex_off", 32'(b0.sysex_active), 32'd0);
    exp_msg(0, 4'h8, 4'h0, 8'h3C, 8'h00);
    send(0, 8'h80); send(0, 8'h3C); send(0, 8'h00);
    chk_err("sysex_no_error", 0);

    // Channel filter on dut2: channel 2 suppressed, channel 3 converted to note off.
    send(2, 8'h92); send(2, 8'h3C); send(2, 8'h40);
    exp_msg(2, 4'h8, 4'h3, 8'h3C, 8'h00);
    send(2, 8'h93); send(2, 8'h3C); send(2, 8'h00);
    chk_err("filter_no_error", 2);

    // Incomplete note interrupted by a controller.
    send(0, 8'h90); send(0, 8'h3C); send(0, 8'hB0);
    e_err[0]++;
    chk_err("interrupt_err", 0);
    exp_msg(0, 4'hB, 4'h0, 8'h07, 8'h7F);
    send(0, 8'h07); send(0, 8'h7F);
    // Status in WAIT_D1 also counts as incomplete.
    send(0, 8'h90); send(0, 8'hC3);
    e_err[0]++;
    chk_err("wait_d1_interrupt_err", 0);
    exp_msg(0, 4'hC, 4'h3, 8'h05, 8'h00);
    send(0, 8'h05);

    // Reset mid-message: outputs cleared, running status lost.
    send(0, 8'h90); send(0, 8'h3C);
    #2 rst_in = 1'b0;
    #2;
    chk("midrst_outs", 32'({b0.status, b0.channel, b0.data_byte1, b0.data_byte2}), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(2);
    send(0, 8'h3C); send(0, 8'h40);
    e_err[0] += 2;
    chk_err("post_rst_err", 0);

    // System common: F2 skips two (real-time not counted), then running status is gone.
    exp_msg(0, 4'h9, 4'h1, 8'h40, 8'h50);
    send(0, 8'h91); send(0, 8'h40); send(0, 8'h50);
    rt_q.push_back({2'd0, 8'hF8});
    send(0, 8'hF2); send(0, 8'h10); send(0, 8'hF8); send(0, 8'h20);
    chk_err("skip_f2_no_error", 0);
    send(0, 8'h41);
    e_err[0]++;
    chk_err("rs_cleared_by_f2", 0);
    // F3 skips one.
    send(0, 8'hF3); send(0, 8'h05);
    exp_msg(0, 4'h9, 4'h2, 8'h10, 8'h20);
    send(0, 8'h92); send(0, 8'h10); send(0, 8'h20);
    // Stray F7.
    send(0, 8'hF7);
    e_err[0]++;
    chk_err("stray_f7_err", 0);
    // F4 clears running status silently.
    exp_msg(0, 4'hC, 4'h1, 8'h05, 8'h00);
    send(0, 8'hC1); send(0, 8'h05); send(0, 8'hF4);
    chk_err("f4_no_error", 0);
    send(0, 8'h06);
    e_err[0]++;
    chk_err("rs_cleared_by_f4", 0);

    // SysEx cut short by channel status, then by F6.
    send(0, 8'hF0); send(0, 8'h01); send(0, 8'h95);
    chk("sysex_cut_by_status", 32'(b0.sysex_active), 32'd0);
    e_err[0]++;
    chk_err("sysex_status_err", 0);
    exp_msg(0, 4'h9, 4'h5, 8'h3C, 8'h40);
    send(0, 8'h3C); send(0, 8'h40);
    send(0, 8'hF0); send(0, 8'h01); send(0, 8'hF6);
    chk("sysex_cut_by_f6", 32'(b0.sysex_active), 32'd0);
    e_err[0]++;
    chk_err("sysex_f6_err", 0);

    idle(4);
    chk("msg_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("rt_queue_drained", 32'(rt_q.size()), 32'd0);
    chk("final_err_dut1", 32'(err_cnt[1]), 32'(e_err[1]));
    chk("final_err_dut2", 32'(err_cnt[2]), 32'(e_err[2]));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
